// File: rtl/spi1_pkg.sv
// spi1_pkg: shared types and widths for the SPI1-to-PET-bus bridge.
package spi1_pkg;
  localparam int SPI1_ADDR_WIDTH = 17;
  localparam int SPI1_DATA_WIDTH = 8;

  typedef enum logic [1:0] {IDLE, WAIT_GRANT, ACCESS, DONE} spi1_state_t;

  typedef struct packed {
    logic [SPI1_ADDR_WIDTH-1:0] addr;
    logic                       rw_n;
    logic [SPI1_DATA_WIDTH-1:0] data;
  } spi1_req_t;
endpackage

// File: rtl/spi1_bus_bridge.sv
// spi1_bus_bridge: performs one byte access on the PET bus during the MCU slot
// for each SPI1 transaction, then completes a four-phase valid/ready handshake.
module spi1_bus_bridge
  import spi1_pkg::*;
#(
  parameter int ACCESS_CYCLES = 2
) (
  input  logic                       clk_i,
  input  logic                       reset_ni,
  input  logic [SPI1_ADDR_WIDTH-1:0] spi_addr_i,
  input  logic                       spi_rw_ni,
  input  logic [SPI1_DATA_WIDTH-1:0] spi_data_i,
  input  logic                       spi_valid_i,
  output logic [SPI1_DATA_WIDTH-1:0] spi_data_o,
  output logic                       spi_ready_o,
  input  logic                       grant_i,
  output logic [SPI1_ADDR_WIDTH-1:0] bus_addr_o,
  output logic [SPI1_DATA_WIDTH-1:0] bus_data_o,
  input  logic [SPI1_DATA_WIDTH-1:0] bus_data_i,
  output logic                       bus_rw_no,
  output logic                       bus_en_o
);
  localparam logic [3:0] CNT_LOAD = 4'(ACCESS_CYCLES - 1);

  spi1_state_t               state_q;
  spi1_req_t                 req_q;
  logic [3:0]                cnt_q;
  logic                      en_q;
  logic                      ready_q;
  logic [SPI1_DATA_WIDTH-1:0] dout_q;

  // Bus side is fed only from the holding register, so SPI input changes after latch never reach the bus.
  assign bus_addr_o  = req_q.addr;
  assign bus_rw_no   = req_q.rw_n;
  assign bus_data_o  = req_q.data;
  assign bus_en_o    = en_q;
  assign spi_ready_o = ready_q;
  assign spi_data_o  = dout_q;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      req_q   <= '{addr: '0, rw_n: 1'b1, data: '0};
      cnt_q   <= '0;
      en_q    <= 1'b0;
      ready_q <= 1'b0;
      dout_q  <= '0;
    end else begin
      case (state_q)
        IDLE: if (spi_valid_i) begin
          req_q   <= '{addr: spi_addr_i, rw_n: spi_rw_ni, data: spi_data_i};
          state_q <= WAIT_GRANT;
        end
        WAIT_GRANT: if (grant_i) begin
          state_q <= ACCESS;
          en_q    <= 1'b1;
          cnt_q   <= CNT_LOAD;
        end
        ACCESS: if (cnt_q == '0) begin
          en_q    <= 1'b0;
          ready_q <= 1'b1;
          state_q <= DONE;
          if (req_q.rw_n) dout_q <= bus_data_i;
        end else begin
          cnt_q <= cnt_q - 4'd1;
        end
        DONE: if (!spi_valid_i) begin
          ready_q <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi1_bus_bridge.sv
// tb_spi1_bus_bridge: three bridges (ACCESS_CYCLES 2, 1, 15) share SPI stimulus and grants;
// a timestamp-based transaction model predicts every output each cycle.
module tb_spi1_bus_bridge;
  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic valid = 1'b0, rw_n = 1'b1, grant = 1'b0;
  logic [16:0] addr = '0;
  logic [7:0] wdata = '0;
  logic en[3], rdy[3], brw[3];
  logic [7:0] dout[3], bdo[3], bd[3];
  logic [16:0] baddr[3];
  bit gen_en = 1'b0, gforce = 1'b0;
  int bmode = 0;
  int checks = 0, fails = 0;
  int ecnt = 0;

  function automatic int acs(input int k);
    return k == 0 ? 2 : (k == 1 ? 1 : 15);
  endfunction

  for (genvar g = 0; g < 3; g++) begin : g_dut
    spi1_bus_bridge #(.ACCESS_CYCLES(acs(g))) u_dut (
      .clk_i(clk), .reset_ni(rst_n),
      .spi_addr_i(addr), .spi_rw_ni(rw_n), .spi_data_i(wdata), .spi_valid_i(valid),
      .spi_data_o(dout[g]), .spi_ready_o(rdy[g]), .grant_i(grant),
      .bus_addr_o(baddr[g]), .bus_data_o(bdo[g]), .bus_data_i(bd[g]),
      .bus_rw_no(brw[g]), .bus_en_o(en[g])
    );
  end

  always #5 clk = ~clk;
  always @(posedge clk) ecnt <= ecnt + 1;
  always @(posedge clk) begin
    #2;
    grant = gen_en ? ($urandom_range(0, 3) == 0) : gforce;
  end

  task automatic chk(input string name, input int k, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s[%0d] got=%0h expected=%0h t=%0t", name, k, act, exp, $time);
    end
  endtask

  // Model: a transaction is latched, granted at edge tg, owns the bus for edges tg..tg+AC-1,
  // completes at tg+AC, and is retired on the first later edge that samples valid low.
  bit have[3], mrdy[3], exp_en[3], rprev[3], vprev;
  int tg[3], runlen[3], en_len[3], acc_cnt[3], lat[3], vrise;
  logic [7:0] mdout[3], mdata[3], ldata[3];
  logic [16:0] maddr[3], laddr[3];
  logic mrw[3], lrw[3];

  always @(negedge clk) begin
    if (!rst_n) begin
      for (int k = 0; k < 3; k++) begin
        chk("rst_en", k, 32'(en[k]), 32'(0));
        chk("rst_rdy", k, 32'(rdy[k]), 32'(0));
        chk("rst_dout", k, 32'(dout[k]), 32'(0));
        have[k] = 0; tg[k] = -1; mrdy[k] = 0; mdout[k] = '0; exp_en[k] = 0; runlen[k] = 0; rprev[k] = 0;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        int n;
        n = ecnt + 1;
        chk("en", k, 32'(en[k]), 32'(exp_en[k]));
        chk("rdy", k, 32'(rdy[k]), 32'(mrdy[k]));
        chk("dout", k, 32'(dout[k]), 32'(mdout[k]));
        if (exp_en[k]) begin
          chk("bus_addr", k, 32'(baddr[k]), 32'(maddr[k]));
          chk("bus_rw", k, 32'(brw[k]), 32'(mrw[k]));
          chk("bus_wdata", k, 32'(bdo[k]), 32'(mdata[k]));
        end
        if (en[k]) begin
          runlen[k]++; laddr[k] = baddr[k]; lrw[k] = brw[k]; ldata[k] = bdo[k];
        end else begin
          if (runlen[k] > 0) begin en_len[k] = runlen[k]; acc_cnt[k]++; end
          runlen[k] = 0;
        end
        if (rdy[k] && !rprev[k]) lat[k] = ecnt + 1 - vrise;
        rprev[k] = rdy[k];
        bd[k] = bmode == 0 ? 8'($urandom) :
                bmode == 1 ? ((en[k] && runlen[k] == acs(k)) ? 8'h3C : 8'hFF) :
                8'h0F + baddr[k][7:0];
        if (!have[k]) begin
          if (valid) begin have[k] = 1; tg[k] = -1; maddr[k] = addr; mrw[k] = rw_n; mdata[k] = wdata; end
        end else if (tg[k] < 0) begin
          if (grant) tg[k] = n;
        end else if (n == tg[k] + acs(k)) begin
          if (mrw[k]) mdout[k] = bd[k];
          mrdy[k] = 1;
        end else if (n > tg[k] + acs(k) && !valid) begin
          have[k] = 0; mrdy[k] = 0;
        end
        exp_en[k] = have[k] && tg[k] >= 0 && n >= tg[k] && n < tg[k] + acs(k);
      end
      if (valid && !vprev) vrise = ecnt + 1;
      vprev = valid;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_all(input bit want);
    for (int i = 0; i < 300; i++) begin
      if (rdy[0] == want && rdy[1] == want && rdy[2] == want) return;
      step();
    end
    checks++; fails++;
    $display("FAIL ready_timeout got=not_all expected=%0d t=%0t", want, $time);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 300; i++) begin
      if (!have[0] && !have[1] && !have[2]) return;
      step();
    end
    checks++; fails++;
    $display("FAIL idle_timeout got=busy expected=idle t=%0t", $time);
  endtask

  task automatic xact();
    valid = 1; step(); gforce = 1; step(); gforce = 0;
    wait_all(1); step();
    valid = 0; wait_all(0); step();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int a0[3];
    #2 rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;
    step();
    addr = 17'h08000; wdata = 8'hA5; rw_n = 0; valid = 1;
    step(); step(); step(); gforce = 1; step(); gforce = 0;
    wait_all(1); step();
    chk("wr_len", 0, 32'(en_len[0]), 32'd2);
    chk("wr_addr", 0, 32'(laddr[0]), 32'h08000);
    chk("wr_rw", 0, 32'(lrw[0]), 32'd0);
    chk("wr_data", 0, 32'(ldata[0]), 32'hA5);
    valid = 0; wait_all(0); step();
    bmode = 1; addr = 17'h00001; rw_n = 1;
    xact();
    for (int k = 0; k < 3; k++) chk("rd_3c", k, 32'(dout[k]), 32'h3C);
    bmode = 0;
    rw_n = 0; valid = 1; step(); gforce = 1; step(); gforce = 0;
    wait_all(1); step();
    for (int k = 0; k < 3; k++) begin
      chk("lat", k, 32'(lat[k]), k == 0 ? 32'd4 : (k == 1 ? 32'd3 : 32'd17));
      chk("en_width", k, 32'(en_len[k]), k == 0 ? 32'd2 : (k == 1 ? 32'd1 : 32'd15));
    end
    valid = 0; wait_all(0); step();
    bmode = 2; rw_n = 0; addr = 17'h0; wdata = 8'h77;
    xact();
    for (int i = 1; i <= 5; i++) begin
      rw_n = 1; addr = 17'(i);
      xact();
      for (int k = 0; k < 3; k++) chk("b2b_rd", k, 32'(dout[k]), 32'(8'h0F + i));
    end
    bmode = 0;
    for (int k = 0; k < 3; k++) a0[k] = acc_cnt[k];
    rw_n = 1; addr = 17'h1ABCD; valid = 1; gforce = 1; step(); gforce = 0; step(); step();
    gforce = 1; step(); step(); step(); gforce = 0;
    wait_all(1); gforce = 1; step(); step(); gforce = 0; step();
    for (int k = 0; k < 3; k++) chk("one_access", k, 32'(acc_cnt[k] - a0[k]), 32'd1);
    valid = 0; wait_all(0); step();
    rw_n = 0; addr = 17'h12345; wdata = 8'h5A; valid = 1; step(); gforce = 1; step(); gforce = 0; step();
    #2 rst_n = 0;
    #1;
    for (int k = 0; k < 3; k++) begin
      chk("arst_en", k, 32'(en[k]), 32'd0);
      chk("arst_rdy", k, 32'(rdy[k]), 32'd0);
      chk("arst_dout", k, 32'(dout[k]), 32'd0);
      chk("arst_rw", k, 32'(brw[k]), 32'd1);
      chk("arst_addr", k, 32'(baddr[k]), 32'd0);
      chk("arst_wdata", k, 32'(bdo[k]), 32'd0);
    end
    valid = 0; step(); step(); rst_n = 1;
    for (int k = 0; k < 3; k++) a0[k] = acc_cnt[k];
    gen_en = 1; repeat (10) step(); gen_en = 0;
    for (int k = 0; k < 3; k++) chk("post_rst_idle", k, 32'(acc_cnt[k] - a0[k]), 32'd0);
    gen_en = 1;
    repeat (60) begin
      addr = 17'($urandom); rw_n = 1'($urandom); wdata = 8'($urandom); valid = 1;
      if ($urandom_range(0, 7) == 0) begin
        repeat ($urandom_range(0, 3)) step();
        valid = 0; addr = 17'($urandom); wdata = 8'($urandom);
        wait_idle();
      end else begin
        step(); wait_all(1);
        repeat ($urandom_range(0, 3)) step();
        valid = 0; addr = 17'($urandom); wdata = 8'($urandom); rw_n = 1'($urandom);
        wait_all(0);
      end
      step();
    end
    gen_en = 0;
    repeat (3) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
